// File: rtl/ctrl_sequencer.sv
// Moore control sequencer for the single-bus CPU datapath: fetch T0-T2, execute T3-T7.
// Strobes are a decode of the current step and the latched opcode, gated off during reset.
module ctrl_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned ALUW = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  ir_op,
  input  logic            mem_ready,
  input  logic            stop,
  output logic            run,
  output logic            pc_out,
  output logic            pc_in,
  output logic            inc_pc,
  output logic            mar_in,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_in,
  output logic            y_in,
  output logic            z_in,
  output logic            zlow_out,
  output logic            c_out,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            r_in,
  output logic            r_out,
  output logic            ba_out,
  output logic [ALUW-1:0] alu_op
);

  localparam logic [OPW-1:0] OpLd   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OpLdi  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OpSt   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OpSub  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OpAddi = OPW'(5'b01100);
  localparam logic [OPW-1:0] OpNop  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OpHalt = OPW'(5'b11011);

  localparam logic [ALUW-1:0] AluAdd = ALUW'(0);
  localparam logic [ALUW-1:0] AluSub = ALUW'(1);

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StIdle, StHalt
  } state_e;

  state_e         state_q;
  state_e         boundary;
  logic [OPW-1:0] op_q;

  logic is_ld, is_ldi, is_st, is_add, is_sub, is_addi, is_halt, is_nop;

  assign is_ld   = (op_q == OpLd);
  assign is_ldi  = (op_q == OpLdi);
  assign is_st   = (op_q == OpSt);
  assign is_add  = (op_q == OpAdd);
  assign is_sub  = (op_q == OpSub);
  assign is_addi = (op_q == OpAddi);
  assign is_halt = (op_q == OpHalt);
  // Unassigned opcodes fall through to NOP timing.
  assign is_nop  = !(is_ld | is_ldi | is_st | is_add | is_sub | is_addi | is_halt);

  assign boundary = stop ? StIdle : StT0;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StT0;
      op_q    <= OpNop;
    end else begin
      unique case (state_q)
        StT0: state_q <= StT1;
        StT1: if (mem_ready) state_q <= StT2;
        StT2: begin
          state_q <= StT3;
          op_q    <= ir_op;
        end
        StT3: begin
          if (is_halt)     state_q <= StHalt;
          else if (is_nop) state_q <= boundary;
          else             state_q <= StT4;
        end
        StT4: state_q <= StT5;
        StT5: state_q <= (is_ld || is_st) ? StT6 : boundary;
        // LD waits for read data in T6; ST waits for write completion in T7.
        StT6: if (is_st || mem_ready) state_q <= StT7;
        StT7: if (!is_st || mem_ready) state_q <= boundary;
        StIdle: if (!stop) state_q <= StT0;
        StHalt: state_q <= StHalt;
        default: state_q <= StT0;
      endcase
    end
  end

  always_comb begin
    run       = 1'b0;
    pc_out    = 1'b0;
    pc_in     = 1'b0;
    inc_pc    = 1'b0;
    mar_in    = 1'b0;
    mdr_in    = 1'b0;
    mdr_out   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    z_in      = 1'b0;
    zlow_out  = 1'b0;
    c_out     = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    r_in      = 1'b0;
    r_out     = 1'b0;
    ba_out    = 1'b0;
    alu_op    = AluAdd;
    if (clr) begin
      run = (state_q != StIdle) && (state_q != StHalt);
      unique case (state_q)
        StT0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
          inc_pc = 1'b1;
          z_in   = 1'b1;
        end
        StT1: begin
          zlow_out = 1'b1;
          pc_in    = mem_ready;
          mem_read = 1'b1;
          mdr_in   = 1'b1;
        end
        StT2: begin
          mdr_out = 1'b1;
          ir_in   = 1'b1;
        end
        StT3: begin
          if (!is_nop && !is_halt) begin
            grb    = 1'b1;
            r_out  = 1'b1;
            y_in   = 1'b1;
            ba_out = is_ldi | is_ld | is_st;
          end
        end
        StT4: begin
          z_in = 1'b1;
          if (is_add || is_sub) begin
            grc    = 1'b1;
            r_out  = 1'b1;
            alu_op = is_sub ? AluSub : AluAdd;
          end else begin
            c_out = 1'b1;
          end
        end
        StT5: begin
          zlow_out = 1'b1;
          if (is_ld || is_st) begin
            mar_in = 1'b1;
          end else begin
            gra  = 1'b1;
            r_in = 1'b1;
          end
        end
        StT6: begin
          mdr_in = 1'b1;
          if (is_st) begin
            gra   = 1'b1;
            r_out = 1'b1;
          end else begin
            mem_read = 1'b1;
          end
        end
        StT7: begin
          if (is_st) begin
            mem_write = 1'b1;
          end else begin
            mdr_out = 1'b1;
            gra     = 1'b1;
            r_in    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: each stimulus cycle pushes the expected strobe vector,
// a negedge monitor pops and compares it against the packed DUT outputs.
module tb_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] ir_op = 5'b11010;
  logic       mem_ready = 1'b1;
  logic       stop = 1'b0;
  logic       run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read, mem_write;
  logic       ir_in, y_in, z_in, zlow_out, c_out, gra, grb, grc, r_in, r_out, ba_out;
  logic [1:0] alu_op;

  always #5 clk = ~clk;

  ctrl_sequencer #(.OPW(5), .ALUW(2)) dut (
    .clk(clk), .clr(clr), .ir_op(ir_op), .mem_ready(mem_ready), .stop(stop),
    .run(run), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .mem_read(mem_read), .mem_write(mem_write),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .c_out(c_out),
    .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
    .alu_op(alu_op)
  );

  localparam logic [21:0] RUN  = 22'd1 << 21;
  localparam logic [21:0] PCO  = 22'd1 << 20;
  localparam logic [21:0] PCI  = 22'd1 << 19;
  localparam logic [21:0] INC  = 22'd1 << 18;
  localparam logic [21:0] MARI = 22'd1 << 17;
  localparam logic [21:0] MDRI = 22'd1 << 16;
  localparam logic [21:0] MDRO = 22'd1 << 15;
  localparam logic [21:0] MRD  = 22'd1 << 14;
  localparam logic [21:0] MWR  = 22'd1 << 13;
  localparam logic [21:0] IRI  = 22'd1 << 12;
  localparam logic [21:0] YI   = 22'd1 << 11;
  localparam logic [21:0] ZI   = 22'd1 << 10;
  localparam logic [21:0] ZLO  = 22'd1 << 9;
  localparam logic [21:0] CO   = 22'd1 << 8;
  localparam logic [21:0] GRA  = 22'd1 << 7;
  localparam logic [21:0] GRB  = 22'd1 << 6;
  localparam logic [21:0] GRC  = 22'd1 << 5;
  localparam logic [21:0] RI   = 22'd1 << 4;
  localparam logic [21:0] RO   = 22'd1 << 3;
  localparam logic [21:0] BA   = 22'd1 << 2;
  localparam logic [21:0] SUBOP = 22'd1;

  localparam logic [4:0] LD = 5'b00000, LDI = 5'b00001, ST = 5'b00010, ADD = 5'b00011;
  localparam logic [4:0] SUB = 5'b00100, NOP = 5'b11010, HALT = 5'b11011, UNK = 5'b10101;

  typedef struct {
    logic [21:0] exp;
    string       tag;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  logic [21:0] act;
  assign act = {run, pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, mem_read, mem_write,
                ir_in, y_in, z_in, zlow_out, c_out, gra, grb, grc, r_in, r_out, ba_out, alu_op};

  // Monitor: compares mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      n_tests++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: outputs %b, required %b", it.tag, act, it.exp);
      end
    end
  end

  task automatic step(input logic [21:0] exp, input logic [4:0] op, input logic mr,
                      input logic st, input logic cl, input string tag);
    item_t it;
    @(posedge clk);
    #1;
    ir_op     = op;
    mem_ready = mr;
    stop      = st;
    clr       = cl;
    it.exp    = exp;
    it.tag    = tag;
    sb.push_back(it);
  endtask

  task automatic fetch(input logic [4:0] op, input int t1_wait);
    step(RUN | PCO | MARI | INC | ZI, op, 1'b1, 1'b0, 1'b1, "t0");
    for (int i = 0; i < t1_wait; i++) step(RUN | ZLO | MRD | MDRI, op, 1'b0, 1'b0, 1'b1, "t1_wait");
    step(RUN | ZLO | MRD | MDRI | PCI, op, 1'b1, 1'b0, 1'b1, "t1");
    step(RUN | MDRO | IRI, op, 1'b1, 1'b0, 1'b1, "t2");
  endtask

  task automatic ld_front(input logic [4:0] op);
    step(RUN | GRB | RO | BA | YI, op, 1'b1, 1'b0, 1'b1, "ldx_t3");
    step(RUN | CO | ZI, op, 1'b1, 1'b0, 1'b1, "ldx_t4");
    step(RUN | ZLO | MARI, op, 1'b1, 1'b0, 1'b1, "ldx_t5");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: everything gated off while clr=0.
    step(22'd0, NOP, 1'b1, 1'b0, 1'b0, "reset0");
    step(22'd0, NOP, 1'b1, 1'b0, 1'b0, "reset1");

    // ADD
    fetch(ADD, 0);
    step(RUN | GRB | RO | YI, ADD, 1'b1, 1'b0, 1'b1, "add_t3");
    step(RUN | GRC | RO | ZI, ADD, 1'b1, 1'b0, 1'b1, "add_t4");
    step(RUN | ZLO | GRA | RI, ADD, 1'b1, 1'b0, 1'b1, "add_t5");

    // LDI
    fetch(LDI, 0);
    step(RUN | GRB | RO | BA | YI, LDI, 1'b1, 1'b0, 1'b1, "ldi_t3");
    step(RUN | CO | ZI, LDI, 1'b1, 1'b0, 1'b1, "ldi_t4");
    step(RUN | ZLO | GRA | RI, LDI, 1'b1, 1'b0, 1'b1, "ldi_t5");

    // LD with 3 wait cycles in T1 and 2 in T6
    fetch(LD, 3);
    ld_front(LD);
    step(RUN | MRD | MDRI, LD, 1'b0, 1'b0, 1'b1, "ld_t6_wait");
    step(RUN | MRD | MDRI, LD, 1'b0, 1'b0, 1'b1, "ld_t6_wait");
    step(RUN | MRD | MDRI, LD, 1'b1, 1'b0, 1'b1, "ld_t6");
    step(RUN | MDRO | GRA | RI, LD, 1'b1, 1'b0, 1'b1, "ld_t7");

    // ST with 2 wait cycles in T7
    fetch(ST, 0);
    ld_front(ST);
    step(RUN | GRA | RO | MDRI, ST, 1'b0, 1'b0, 1'b1, "st_t6");
    step(RUN | MWR, ST, 1'b0, 1'b0, 1'b1, "st_t7_wait");
    step(RUN | MWR, ST, 1'b0, 1'b0, 1'b1, "st_t7_wait");
    step(RUN | MWR, ST, 1'b1, 1'b0, 1'b1, "st_t7");

    // SUB with stop raised in T4: completes, then idles
    fetch(SUB, 0);
    step(RUN | GRB | RO | YI, SUB, 1'b1, 1'b0, 1'b1, "sub_t3");
    step(RUN | GRC | RO | ZI | SUBOP, SUB, 1'b1, 1'b1, 1'b1, "sub_t4");
    step(RUN | ZLO | GRA | RI, SUB, 1'b1, 1'b1, 1'b1, "sub_t5");
    step(22'd0, SUB, 1'b1, 1'b1, 1'b1, "idle");
    step(22'd0, SUB, 1'b1, 1'b0, 1'b1, "idle_release");

    // Unassigned opcode behaves as NOP
    fetch(UNK, 0);
    step(RUN, UNK, 1'b1, 1'b0, 1'b1, "unk_t3");

    // Reset in the middle of LD (T6)
    fetch(LD, 0);
    ld_front(LD);
    step(RUN | MRD | MDRI, LD, 1'b0, 1'b0, 1'b1, "ld2_t6_wait");
    step(22'd0, LD, 1'b0, 1'b0, 1'b0, "midld_reset");
    step(22'd0, LD, 1'b1, 1'b0, 1'b0, "midld_reset_hold");

    // HALT absorbs until clr
    fetch(HALT, 0);
    step(RUN, HALT, 1'b1, 1'b0, 1'b1, "halt_t3");
    for (int i = 0; i < 4; i++) step(22'd0, HALT, 1'b1, 1'b0, 1'b1, "halted");
    step(22'd0, HALT, 1'b1, 1'b0, 1'b0, "halt_clr");

    // NOP after leaving HALT
    fetch(NOP, 0);
    step(RUN, NOP, 1'b1, 1'b0, 1'b1, "nop_t3");
    step(RUN | PCO | MARI | INC | ZI, NOP, 1'b1, 1'b0, 1'b1, "next_t0");

    @(posedge clk);
    @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
Moore-type control sequencer for the single-bus register-transfer CPU datapath. It steps each instruction through fetch (T0-T2) and execute (T3-T7) phases, and drives the register-file select/in/out strobes, the base-address zero-force (ba_out), the PC/MAR/MDR/Y/Z strobes, the ALU operation and the memory read/write strobes. It sits beside the datapath and takes the IR opcode plus a memory-ready handshake.

Parameters:
OPW, 5, opcode width (IR[31:27])
ALUW, 2, width of alu_op

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset
ir_op  in  5  opcode field IR[31:27]
mem_ready  in  1  memory completes the current read/write this cycle
stop  in  1  request to pause at the next instruction boundary
run  out  1  high while sequencing (not in IDLE or HALT)
pc_out, pc_in, inc_pc  out  1 each  PC strobes
mar_in, mdr_in, mdr_out  out  1 each  memory interface register strobes
mem_read  out  1  MDR loads from memory (with mdr_in); 0 means MDR loads from the bus
mem_write  out  1  memory write strobe
ir_in, y_in, z_in, zlow_out, c_out  out  1 each  IR/Y/Z/immediate strobes
gra, grb, grc  out  1 each  register-field selects (to select/encode logic)
r_in, r_out, ba_out  out  1 each  register-file write, read and read-as-zero strobes
alu_op  out  ALUW  00=ADD, 01=SUB, others reserved

Behaviour:
- Opcodes: LD=00000, LDI=00001, ST=00010, ADD=00011, SUB=00100, ADDI=01100, NOP=11010, HALT=11011. Any other opcode executes as NOP.
- States: T0..T7, IDLE, HALT (one-hot or encoded). Every output is a pure decode of the current state and the latched opcode, asserted for the whole cycle. Any output not listed for a step is 0. alu_op defaults to 00.
- Reset (clr=0, asynchronous, also mid-instruction): state=T0, all outputs 0 except the T0 decode, which is gated off while clr=0. Latched opcode clears to NOP. First fetch begins on the first clock edge after clr rises, so run=0 while clr=0.
- Fetch:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, mem_read, mdr_in. Hold in T1 while mem_ready=0; pc_in is asserted only in the cycle with mem_ready=1.
  - T2: mdr_out, ir_in. ir_op is latched on exit from T2 (next clk edge).
- ADD/SUB: T3 grb, r_out, y_in; T4 grc, r_out, alu_op=ADD/SUB, z_in; T5 zlow_out, gra, r_in.
- ADDI: T3 grb, r_out, y_in; T4 c_out, ADD, z_in; T5 zlow_out, gra, r_in.
- LDI: T3 grb, r_out, ba_out, y_in; T4 c_out, ADD, z_in; T5 zlow_out, gra, r_in.
- LD: T3-T4 as LDI; T5 zlow_out, mar_in; T6 mem_read, mdr_in (hold while mem_ready=0); T7 mdr_out, gra, r_in.
- ST: T3-T5 as LD; T6 gra, r_out, mdr_in (mem_read=0); T7 mem_write (hold while mem_ready=0).
- NOP: T3 only, no strobes.
- HALT: T3 moves to HALT. HALT is absorbing until clr; run=0.
- Instruction boundary: on leaving the last execute step, go to T0 if stop=0, else IDLE. In IDLE, return to T0 when stop=0. stop is ignored mid-instruction.
- Wait states: every strobe of a held state stays asserted, unchanged, each held cycle. There is no timeout.
- r_in and mem_write are never high in the same cycle. r_in is high for exactly one cycle per register-writing instruction.

Test Plan:
- Reset mid-LD (clr low in T6) -> outputs 0 immediately; after release, T0 with pc_out=mar_in=inc_pc=z_in=1, run=1 one cycle later.
- ADD, mem_ready tied 1 -> 6 cycles T0-T5; T4 alu_op=00, grc=r_out=z_in=1; T5 gra=r_in=1; next cycle back in T0.
- LDI -> T3 asserts grb=r_out=ba_out=y_in=1; total 6 cycles; ba_out=0 in every other cycle.
- LD with mem_ready low 3 cycles in T1 and 2 cycles in T6 -> 13 total cycles; strobes held stable while waiting; r_in pulses once in T7.
- ST -> T6 mdr_in=1 with mem_read=0; T7 mem_write held until mem_ready=1; r_in never asserted.
- stop=1 during SUB T4 -> SUB completes, enters IDLE with run=0; stop=0 -> T0 next cycle. HALT opcode -> run=0 permanently until clr pulse. Opcode 10101 -> NOP timing (4 cycles).
